// File: rtl/pipe_pkg.sv
// pipe_pkg: types and helpers shared by the pipeline hazard logic.
//   hz_state_t : hazard controller sequencing state
//   REG_ZERO   : hard-wired zero register index (never a hazard source)
//   reg_match  : producer/consumer register dependency test
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDBUSY    = 2'd1,
        EXC_DRAIN = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A younger instruction depends on an older one only if the older one
    // really writes a register other than $zero and that register is read.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic       wr);
        return (rd != REG_ZERO) & wr & (rd == rs);
    endfunction

endpackage

// File: rtl/muldiv_busy_tracker.sv
// muldiv_busy_tracker: busy counter for the multi-cycle HI/LO unit.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   start_i  : a MULT/DIV leaves ID this cycle
//   abort_i  : exception kills the in-flight operation (wins over start)
//   busy_o   : unit busy (registered)
//   done_o   : last busy cycle (counter reached zero while busy)
module muldiv_busy_tracker #(
    parameter int LATENCY = 32,
    parameter int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic abort_i,
    output logic busy_o,
    output logic done_o
);

    // Busy for exactly LATENCY cycles: the load value counts the first
    // busy cycle, and the count reaching zero marks the last one.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    always_comb begin
        busy_d   = busy_q;
        md_cnt_d = md_cnt_q;
        if (abort_i) begin
            busy_d   = 1'b0;
            md_cnt_d = '0;
        end else if (start_i) begin
            busy_d   = 1'b1;
            md_cnt_d = LOAD_VAL;
        end else if (busy_q) begin
            // Counts down every cycle regardless of pipeline stalls.
            if (md_cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                md_cnt_d = md_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            md_cnt_q <= '0;
        end else begin
            busy_q   <= busy_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q & (md_cnt_q == '0);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush generator for the 5-stage MIPS-III pipeline.
// A stalled stage holds while a bubble enters the next stage; a flush clears
// the younger stages. Outputs are combinational from inputs and state.
// Ports:
//   CLK, RST                      : clock, synchronous active-high reset
//   ID_Rs/ID_Rt                   : ID source registers
//   ID_WantRs/ID_WantRt           : source needed in EX (forwardable)
//   ID_NeedRs/ID_NeedRt           : source needed in ID (branch compare)
//   EX_Rd/EX_RegWrite/EX_MemRead  : EX producer
//   M_Rd/M_RegWrite/M_MemRead     : MEM producer
//   ID_MulDivStart/ID_MulDivRead  : MULT/DIV issue, HI/LO access in ID
//   IF_Busy/M_Busy                : instruction/data memory not ready
//   EXC_Request                   : exception raised in MEM
//   IF/ID/EX/M_Stall              : stage stalls
//   IF/ID/EX_Flush                : stage flushes
//   MulDivBusy                    : HI/LO unit busy
//   PerfStallCnt/PerfFlushCnt     : cycle counters, present only when
//                                   HAZARD_PERF_CNT_EN is defined
module hazard_controller
    import pipe_pkg::*;
#(
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_W          = $clog2(MULDIV_LATENCY + 1)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_WantRs,
    input  logic       ID_WantRt,
    input  logic       ID_NeedRs,
    input  logic       ID_NeedRt,
    input  logic [4:0] EX_Rd,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic [4:0] M_Rd,
    input  logic       M_RegWrite,
    input  logic       M_MemRead,
    input  logic       ID_MulDivStart,
    input  logic       ID_MulDivRead,
    input  logic       IF_Busy,
    input  logic       M_Busy,
    input  logic       EXC_Request,
    output logic       IF_Stall,
    output logic       ID_Stall,
    output logic       EX_Stall,
    output logic       M_Stall,
    output logic       IF_Flush,
    output logic       ID_Flush,
    output logic       EX_Flush,
    output logic       MulDivBusy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] PerfStallCnt,
    output logic [31:0] PerfFlushCnt
`endif
);

    hz_state_t state_q, state_d;

    logic [1:0][4:0] src_reg;
    logic [1:0]      src_want, src_need;
    logic [1:0]      ld_use_v, br_ex_v, br_m_v;

    logic ld_use, br_ex, br_m, md_rd;
    logic md_busy, md_done, md_start;
    logic flush_raw, m_stall_raw, ex_stall_raw, id_stall_raw, if_stall_raw;

    assign src_reg  = {ID_Rt, ID_Rs};
    assign src_want = {ID_WantRt, ID_WantRs};
    assign src_need = {ID_NeedRt, ID_NeedRs};

    // Per-source hazard detection, index 0 = Rs, index 1 = Rt.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic ex_hit, m_hit;
            assign ex_hit = reg_match(EX_Rd, src_reg[gi], EX_RegWrite);
            assign m_hit  = reg_match(M_Rd,  src_reg[gi], M_RegWrite);
            // A load in EX cannot forward to EX or ID in time.
            assign ld_use_v[gi] = EX_MemRead & ex_hit & (src_want[gi] | src_need[gi]);
            // Branch compares in ID: an EX result is too late, a load in
            // MEM is too late; an ALU result in MEM is forwardable.
            assign br_ex_v[gi]  = ex_hit & src_need[gi];
            assign br_m_v[gi]   = M_MemRead & m_hit & src_need[gi];
        end
    endgenerate

    assign ld_use = |ld_use_v;
    assign br_ex  = |br_ex_v;
    assign br_m   = |br_m_v;
    assign md_rd  = ID_MulDivRead & md_busy;

    // Flush covers the request cycle and the single drain cycle after it.
    assign flush_raw    = EXC_Request | (state_q == EXC_DRAIN);
    assign m_stall_raw  = M_Busy;
    assign ex_stall_raw = m_stall_raw;
    // While flushing, ID holds a dead instruction, so its own hazards are moot.
    assign id_stall_raw = flush_raw ? ex_stall_raw
                                    : (ex_stall_raw | ld_use | br_ex | br_m | md_rd);
    assign if_stall_raw = id_stall_raw | IF_Busy;

    // Start only counts when the MULT/DIV actually leaves ID.
    assign md_start = (state_q == RUN) & ID_MulDivStart & ~id_stall_raw & ~EXC_Request;

    muldiv_busy_tracker #(
        .LATENCY (MULDIV_LATENCY),
        .CNT_W   (CNT_W)
    ) u_md_tracker (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (md_start),
        .abort_i (EXC_Request),
        .busy_o  (md_busy),
        .done_o  (md_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (md_start) state_d = MDBUSY;
            MDBUSY:    if (md_done)  state_d = RUN;
            EXC_DRAIN: state_d = RUN;
            default:   state_d = RUN;
        endcase
        // An exception pre-empts everything, including an in-flight mul/div.
        if (EXC_Request) begin
            state_d = EXC_DRAIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // All outputs are held low while reset is asserted.
    assign M_Stall    = ~RST & m_stall_raw;
    assign EX_Stall   = ~RST & ex_stall_raw;
    assign ID_Stall   = ~RST & id_stall_raw;
    assign IF_Stall   = ~RST & if_stall_raw;
    assign IF_Flush   = ~RST & flush_raw;
    assign ID_Flush   = ~RST & flush_raw;
    assign EX_Flush   = ~RST & flush_raw;
    assign MulDivBusy = ~RST & (state_q == MDBUSY);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Free-running 32-bit counters; natural wrap at 2^32.
    assign perf_stall_d = perf_stall_q + {31'd0, ID_Stall};
    assign perf_flush_d = perf_flush_q + {31'd0, ID_Flush};

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign PerfStallCnt = perf_stall_q;
    assign PerfFlushCnt = perf_flush_q;
`endif

endmodule
